// File: rtl/adsr_amp_pkg.sv
// Shared definitions for the ADSR voice amplifier: default widths, sample-rate constants and state encoding.
// Optional build macro: ADSR_EXP_DECAY_EN (exponential-ish decay/release curve).
package adsr_amp_pkg;

    localparam int BITDEPTH_DEF    = 14;
    localparam int VOLBITS_DEF     = 8;
    localparam int FRACBITS_DEF    = 8;
    localparam int RATEBITS_DEF    = 8;
    localparam int SAMPLECLOCK_DIV = 32;
    localparam int SAMPLEFREQ      = 31250;

    // acc is shifted right by this amount and added to the rate in the exponential curve
    localparam int EXP_SHIFT = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_amp_if.sv
// Voice amplifier port bundle. No valid/ready: every signal is sampled on each sample_clock rising edge,
// and the outputs are valid between edges.
interface adsr_amp_if #(
    parameter int BITDEPTH = 14,
    parameter int VOLBITS  = 8,
    parameter int RATEBITS = 8
);
    logic signed [BITDEPTH-1:0]  i_in;
    logic                        i_gate;
    logic [RATEBITS-1:0]         i_attack;
    logic [RATEBITS-1:0]         i_decay;
    logic [VOLBITS-1:0]          i_sustain;
    logic [RATEBITS-1:0]         i_release;
    logic signed [BITDEPTH-1:0]  o_out;
    logic [VOLBITS-1:0]          o_volume;
    logic                        o_busy;
    adsr_amp_pkg::adsr_state_t   o_state;

    modport master (
        output i_in, i_gate, i_attack, i_decay, i_sustain, i_release,
        input  o_out, o_volume, o_busy, o_state
    );

    modport slave (
        input  i_in, i_gate, i_attack, i_decay, i_sustain, i_release,
        output o_out, o_volume, o_busy, o_state
    );
endinterface

// File: rtl/adsr_amp_envelope.sv
// ADSR state machine and envelope accumulator; volume is the top VOLBITS of the accumulator.
// Optional build macro: ADSR_EXP_DECAY_EN adds acc>>EXP_SHIFT to the decay/release step.
module adsr_envelope
    import adsr_amp_pkg::*;
#(
    parameter int VOLBITS  = VOLBITS_DEF,
    parameter int FRACBITS = FRACBITS_DEF,
    parameter int RATEBITS = RATEBITS_DEF
) (
    input  logic                sample_clock,
    input  logic                reset,
    input  logic                i_gate,
    input  logic                i_gate_d,
    input  logic [RATEBITS-1:0] i_attack,
    input  logic [RATEBITS-1:0] i_decay,
    input  logic [VOLBITS-1:0]  i_sustain,
    input  logic [RATEBITS-1:0] i_release,
    output logic [VOLBITS-1:0]  o_volume,
    output logic                o_busy,
    output adsr_state_t         o_state
);
    localparam int ACCBITS = VOLBITS + FRACBITS;
    localparam logic [ACCBITS:0] ONE = (ACCBITS + 1)'(1);

    logic [ACCBITS-1:0] r_acc;
    adsr_state_t        r_state;

    logic [ACCBITS-1:0] w_tgt;
    logic [ACCBITS:0]   w_att_sum;
    logic [ACCBITS:0]   w_dec_step;
    logic [ACCBITS:0]   w_rel_step;
    logic [ACCBITS:0]   w_dec_diff;
    logic [ACCBITS:0]   w_rel_diff;

    // All arithmetic is one bit wider than acc so bit ACCBITS is the carry/borrow.
    always_comb begin
        w_tgt     = {i_sustain, {FRACBITS{1'b0}}};
        w_att_sum = {1'b0, r_acc} + (ACCBITS + 1)'(i_attack) + ONE;
`ifdef ADSR_EXP_DECAY_EN
        w_dec_step = {1'b0, r_acc >> EXP_SHIFT} + (ACCBITS + 1)'(i_decay) + ONE;
        w_rel_step = {1'b0, r_acc >> EXP_SHIFT} + (ACCBITS + 1)'(i_release) + ONE;
`else
        w_dec_step = (ACCBITS + 1)'(i_decay) + ONE;
        w_rel_step = (ACCBITS + 1)'(i_release) + ONE;
`endif
        w_dec_diff = {1'b0, r_acc} - w_dec_step;
        w_rel_diff = {1'b0, r_acc} - w_rel_step;
    end

    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_state <= ST_IDLE;
        end else if (i_gate && !i_gate_d) begin
            // Retrigger keeps the current level to avoid a click.
            r_state <= ST_ATTACK;
        end else if (!i_gate && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                                 r_state == ST_SUSTAIN)) begin
            r_state <= ST_RELEASE;
        end else begin
            case (r_state)
                ST_IDLE: r_acc <= '0;
                ST_ATTACK: begin
                    if (w_att_sum[ACCBITS] || (&w_att_sum[ACCBITS-1:0])) begin
                        r_acc   <= '1;
                        r_state <= ST_DECAY;
                    end else begin
                        r_acc <= w_att_sum[ACCBITS-1:0];
                    end
                end
                ST_DECAY: begin
                    if (w_dec_diff[ACCBITS] || (w_dec_diff[ACCBITS-1:0] <= w_tgt)) begin
                        r_acc   <= w_tgt;
                        r_state <= ST_SUSTAIN;
                    end else begin
                        r_acc <= w_dec_diff[ACCBITS-1:0];
                    end
                end
                ST_SUSTAIN: r_acc <= w_tgt;
                ST_RELEASE: begin
                    if (w_rel_diff[ACCBITS] || (w_rel_diff[ACCBITS-1:0] == '0)) begin
                        r_acc   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= w_rel_diff[ACCBITS-1:0];
                    end
                end
                default: begin
                    r_acc   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_volume = r_acc[ACCBITS-1 -: VOLBITS];
    assign o_busy   = (r_state != ST_IDLE);
    assign o_state  = r_state;

endmodule

// File: rtl/adsr_amp.sv
// Per-voice ADSR envelope plus signed VCA: registers the gate, scales the input by the envelope level.
// Optional build macro: ADSR_EXP_DECAY_EN (passed through to the envelope).
module adsr_amp
    import adsr_amp_pkg::*;
#(
    parameter int BITDEPTH = BITDEPTH_DEF,
    parameter int VOLBITS  = VOLBITS_DEF,
    parameter int FRACBITS = FRACBITS_DEF,
    parameter int RATEBITS = RATEBITS_DEF
) (
    input logic       sample_clock,
    input logic       reset,
    adsr_amp_if.slave bus
);
    localparam int PRODBITS = BITDEPTH + VOLBITS;

    logic                       r_gate_d;
    logic signed [BITDEPTH-1:0] r_out;
    logic [VOLBITS-1:0]         w_volume;
    logic                       w_busy;
    adsr_state_t                w_state;
    logic signed [PRODBITS-1:0] w_in_ext;
    logic signed [PRODBITS-1:0] w_vol_ext;
    logic signed [PRODBITS-1:0] w_prod;

    adsr_envelope #(
        .VOLBITS  (VOLBITS),
        .FRACBITS (FRACBITS),
        .RATEBITS (RATEBITS)
    ) u_env (
        .sample_clock (sample_clock),
        .reset        (reset),
        .i_gate       (bus.i_gate),
        .i_gate_d     (r_gate_d),
        .i_attack     (bus.i_attack),
        .i_decay      (bus.i_decay),
        .i_sustain    (bus.i_sustain),
        .i_release    (bus.i_release),
        .o_volume     (w_volume),
        .o_busy       (w_busy),
        .o_state      (w_state)
    );

    // Volume is treated as a non-negative signed factor; the product always fits PRODBITS.
    assign w_in_ext  = {{VOLBITS{bus.i_in[BITDEPTH-1]}}, bus.i_in};
    assign w_vol_ext = {{BITDEPTH{1'b0}}, w_volume};
    assign w_prod    = w_in_ext * w_vol_ext;

    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            r_gate_d <= 1'b0;
            r_out    <= '0;
        end else begin
            r_gate_d <= bus.i_gate;
            r_out    <= w_prod[PRODBITS-1 -: BITDEPTH];
        end
    end

    assign bus.o_out    = r_out;
    assign bus.o_volume = w_volume;
    assign bus.o_busy   = w_busy;
    assign bus.o_state  = w_state;

endmodule

// File: tb/tb_adsr_amp.sv
// Bench for adsr_amp: directed table, hand-written corner sequences, and randomized runs
// checked every cycle against an integer envelope/VCA model.
module tb_adsr_amp;
    localparam int BD = 14;
    localparam int VB = 8;
    localparam int RB = 8;
    localparam int ACC_MAX = (1 << (VB + 8)) - 1;

    localparam int M_IDLE    = 0;
    localparam int M_ATTACK  = 1;
    localparam int M_DECAY   = 2;
    localparam int M_SUSTAIN = 3;
    localparam int M_RELEASE = 4;

    logic sample_clock = 1'b0;
    logic reset        = 1'b0;

    adsr_amp_if #(.BITDEPTH(BD), .VOLBITS(VB), .RATEBITS(RB)) bus ();

    adsr_amp #(.BITDEPTH(BD), .VOLBITS(VB), .FRACBITS(8), .RATEBITS(RB)) dut (
        .sample_clock (sample_clock),
        .reset        (reset),
        .bus          (bus.slave)
    );

    always #5 sample_clock = ~sample_clock;

    int checks = 0;
    int errors = 0;

    int m_acc    = 0;
    int m_stage  = M_IDLE;
    int m_gate_d = 0;
    int m_out    = 0;

    typedef struct {
        logic gate;
        int   sustain;
        int   in_val;
        int   cycles;
        int   exp_vol;
        int   exp_state;
        int   exp_busy;
        int   exp_out;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc    = 0;
        m_stage  = M_IDLE;
        m_gate_d = 0;
        m_out    = 0;
    endtask

    // One sample: the output uses the level and input present before the edge.
    task automatic model_edge();
        int vol;
        int tgt;
        int step;
        vol   = m_acc / 256;
        m_out = (int'(bus.i_in) * vol) >>> 8;
        tgt   = int'(bus.i_sustain) * 256;
        if (bus.i_gate && m_gate_d == 0) begin
            m_stage = M_ATTACK;
        end else if (!bus.i_gate && (m_stage == M_ATTACK || m_stage == M_DECAY ||
                                     m_stage == M_SUSTAIN)) begin
            m_stage = M_RELEASE;
        end else begin
            case (m_stage)
                M_ATTACK: begin
                    m_acc = m_acc + int'(bus.i_attack) + 1;
                    if (m_acc >= ACC_MAX) begin
                        m_acc   = ACC_MAX;
                        m_stage = M_DECAY;
                    end
                end
                M_DECAY: begin
                    step = int'(bus.i_decay) + 1;
`ifdef ADSR_EXP_DECAY_EN
                    step = step + m_acc / 64;
`endif
                    m_acc = m_acc - step;
                    if (m_acc <= tgt) begin
                        m_acc   = tgt;
                        m_stage = M_SUSTAIN;
                    end
                end
                M_SUSTAIN: m_acc = tgt;
                M_RELEASE: begin
                    step = int'(bus.i_release) + 1;
`ifdef ADSR_EXP_DECAY_EN
                    step = step + m_acc / 64;
`endif
                    m_acc = m_acc - step;
                    if (m_acc <= 0) begin
                        m_acc   = 0;
                        m_stage = M_IDLE;
                    end
                end
                default: m_acc = 0;
            endcase
        end
        m_gate_d = bus.i_gate ? 1 : 0;
    endtask

    task automatic check_model();
        chk("model_volume", int'(bus.o_volume), m_acc / 256);
        chk("model_state", int'(bus.o_state), m_stage);
        chk("model_busy", int'(bus.o_busy), (m_stage != M_IDLE) ? 1 : 0);
        chk("model_out", int'(bus.o_out), m_out);
    endtask

    task automatic tick();
        @(posedge sample_clock);
        model_edge();
        @(negedge sample_clock);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge sample_clock);
        reset = 1'b1;
        model_reset();
        @(negedge sample_clock);
        reset = 1'b0;
    endtask

    task automatic run_until_stage(input int st, input int limit);
        int n;
        n = 0;
        while (m_stage != st && n < limit) begin
            tick();
            n++;
        end
        chk("reach_stage", int'(bus.o_state), st);
    endtask

    task automatic run_until_vol(input int v, input int limit);
        int n;
        n = 0;
        while ((m_acc / 256) != v && n < limit) begin
            tick();
            n++;
        end
        chk("reach_volume", int'(bus.o_volume), v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 128, 8191,   1,   0, M_ATTACK,  1,    0};
        vecs[1] = '{1'b1, 128, 8191, 255, 255, M_ATTACK,  1, 8127};
        vecs[2] = '{1'b1, 128, 8191,   1, 255, M_DECAY,   1, 8159};
        vecs[3] = '{1'b1, 128, 8191, 128, 128, M_SUSTAIN, 1, 4095};
        vecs[4] = '{1'b1,  64, 8191,   1,  64, M_SUSTAIN, 1, 4095};
        vecs[5] = '{1'b1, 128, 8191,   1, 128, M_SUSTAIN, 1, 2047};
        vecs[6] = '{1'b0, 128, 8191,   1, 128, M_RELEASE, 1, 4095};
        vecs[7] = '{1'b0, 128, 8191, 127,   1, M_RELEASE, 1,   63};
        vecs[8] = '{1'b0, 128, 8191,   1,   0, M_IDLE,    0,   31};
        vecs[9] = '{1'b0, 128, 8191,   3,   0, M_IDLE,    0,    0};

        bus.i_in      = '0;
        bus.i_gate    = 1'b0;
        bus.i_attack  = 8'd255;
        bus.i_decay   = 8'd255;
        bus.i_sustain = 8'd128;
        bus.i_release = 8'd255;

        do_reset();
        chk("reset_volume", int'(bus.o_volume), 0);
        chk("reset_busy", int'(bus.o_busy), 0);
        chk("reset_out", int'(bus.o_out), 0);
        chk("reset_state", int'(bus.o_state), M_IDLE);

        // Directed full ADSR cycle
        for (int i = 0; i < 10; i++) begin
            bus.i_gate    = vecs[i].gate;
            bus.i_sustain = 8'(vecs[i].sustain);
            bus.i_in      = 14'(vecs[i].in_val);
            for (int c = 0; c < vecs[i].cycles; c++) tick();
            chk($sformatf("vec%0d_volume", i), int'(bus.o_volume), vecs[i].exp_vol);
            chk($sformatf("vec%0d_state", i), int'(bus.o_state), vecs[i].exp_state);
            chk($sformatf("vec%0d_busy", i), int'(bus.o_busy), vecs[i].exp_busy);
            chk($sformatf("vec%0d_out", i), int'(bus.o_out), vecs[i].exp_out);
        end

        // Retrigger during release at volume 40 continues upward from 40
        bus.i_gate = 1'b1;
        run_until_stage(M_SUSTAIN, 800);
        bus.i_gate = 1'b0;
        run_until_vol(40, 400);
        bus.i_gate = 1'b1;
        tick();
        chk("retrig_state", int'(bus.o_state), M_ATTACK);
        chk("retrig_volume", int'(bus.o_volume), 40);
        tick();
        chk("retrig_rise", int'(bus.o_volume), 41);

        // Retrigger on the edge where release would reach zero
        run_until_stage(M_SUSTAIN, 800);
        bus.i_gate = 1'b0;
        run_until_vol(1, 400);
        chk("pre_zero_state", int'(bus.o_state), M_RELEASE);
        bus.i_gate = 1'b1;
        tick();
        chk("zero_race_state", int'(bus.o_state), M_ATTACK);
        chk("zero_race_volume", int'(bus.o_volume), 1);
        chk("zero_race_busy", int'(bus.o_busy), 1);

        // Full-scale sustain: decay lasts one cycle; negative full-scale input
        do_reset();
        bus.i_gate    = 1'b1;
        bus.i_sustain = 8'd255;
        bus.i_in      = 14'sh2000;
        run_until_stage(M_DECAY, 400);
        tick();
        chk("sus_max_state", int'(bus.o_state), M_SUSTAIN);
        chk("sus_max_volume", int'(bus.o_volume), 255);
        tick();
        chk("neg_full_out", int'(bus.o_out), -8160);

        // Zero sustain with gate held
        do_reset();
        bus.i_sustain = 8'd0;
        bus.i_in      = 14'sh1FFF;
        run_until_stage(M_SUSTAIN, 800);
        tick();
        chk("sus0_volume", int'(bus.o_volume), 0);
        chk("sus0_busy", int'(bus.o_busy), 1);
        chk("sus0_out", int'(bus.o_out), 0);

        // Asynchronous reset between edges mid-attack
        do_reset();
        bus.i_sustain = 8'd128;
        bus.i_attack  = 8'd100;
        for (int c = 0; c < 60; c++) tick();
        chk("pre_areset_busy", int'(bus.o_busy), 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("areset_out", int'(bus.o_out), 0);
        chk("areset_volume", int'(bus.o_volume), 0);
        chk("areset_busy", int'(bus.o_busy), 0);
        chk("areset_state", int'(bus.o_state), M_IDLE);
        #1;
        reset = 1'b0;
        bus.i_gate = 1'b0;

        // Randomized gate/rate/level runs
        for (int s = 0; s < 40; s++) begin
            int hold;
            bus.i_gate    = 1'($urandom_range(0, 1));
            bus.i_attack  = 8'($urandom_range(40, 255));
            bus.i_decay   = 8'($urandom_range(0, 255));
            bus.i_release = 8'($urandom_range(40, 255));
            bus.i_sustain = 8'($urandom_range(0, 255));
            hold = $urandom_range(1, 300);
            for (int c = 0; c < hold; c++) begin
                bus.i_in = 14'($urandom_range(0, 16383));
                if ($urandom_range(0, 99) == 0) bus.i_sustain = 8'($urandom_range(0, 255));
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
